// File: rtl/uart_loader_host_if.sv
// +----------------------------------------------------------------------+
// | uart_loader_host_if : control, ROM and result-stream bundle          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface uart_loader_host_if;
  logic        start;
  logic [31:0] prog_words;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        busy;
  logic        done;
  logic        err;

  modport master (
    output start, prog_words, rom_data,
    input  rom_addr, out_data, out_valid, busy, done, err
  );

  modport slave (
    input  start, prog_words, rom_data,
    output rom_addr, out_data, out_valid, busy, done, err
  );
endinterface

`default_nettype wire

// File: rtl/uart_loader_host.sv
// +----------------------------------------------------------------------+
// | uart_loader_host : host-side peer of the UART program loader, with   |
// | uart_tx / uart_rx. Optional macro UART_HOST_FERR_EN drops ferr bytes.|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module uart_tx #(
  parameter int CLK_PER_HALF_BIT = 217
) (
  input  wire logic       clk,
  input  wire logic       rst,
  input  wire logic       i_start,
  input  wire logic [7:0] i_data,
  output logic            o_txd,
  output logic            o_busy
);
  localparam logic [31:0] c_BIT_LAST = 32'(2 * CLK_PER_HALF_BIT - 1);

  logic [8:0]  r_sh;
  logic [3:0]  r_nbit;
  logic [31:0] r_cnt;
  logic        r_txd;
  logic        r_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sh <= '0; r_nbit <= '0; r_cnt <= '0; r_txd <= 1'b1; r_busy <= 1'b0;
    end else if (!r_busy) begin
      if (i_start) begin
        r_sh <= {1'b1, i_data}; r_nbit <= '0; r_cnt <= '0;
        r_txd <= 1'b0; r_busy <= 1'b1;
      end
    end else if (r_cnt != c_BIT_LAST) begin
      r_cnt <= r_cnt + 32'd1;
    end else begin
      r_cnt <= '0;
      if (r_nbit == 4'd9) begin
        r_busy <= 1'b0; r_txd <= 1'b1;
      end else begin
        r_txd <= r_sh[0]; r_sh <= {1'b1, r_sh[8:1]}; r_nbit <= r_nbit + 4'd1;
      end
    end
  end

  assign o_txd  = r_txd;
  assign o_busy = r_busy;
endmodule

module uart_rx #(
  parameter int CLK_PER_HALF_BIT = 217
) (
  input  wire logic       clk,
  input  wire logic       rst,
  input  wire logic       i_rxd,
  output logic [7:0]      o_data,
  output logic            o_ready,
  output logic            o_ferr
);
  logic        r_s1, r_s2, r_act, r_ready, r_ferr;
  logic [3:0]  r_nbit;
  logic [31:0] r_cnt;
  logic [7:0]  r_sh, r_data;
  logic [31:0] w_lim;

  // First interval lands mid start bit, later ones step a full bit.
  assign w_lim = (r_nbit == 4'd0) ? 32'(CLK_PER_HALF_BIT - 1) : 32'(2 * CLK_PER_HALF_BIT - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= 1'b1; r_s2 <= 1'b1; r_act <= 1'b0; r_nbit <= '0; r_cnt <= '0;
      r_sh <= '0; r_data <= '0; r_ready <= 1'b0; r_ferr <= 1'b0;
    end else begin
      r_s1 <= i_rxd;
      r_s2 <= r_s1;
      if (!r_act) begin
        if (!r_s2) begin
          r_act <= 1'b1; r_cnt <= '0; r_nbit <= '0; r_ready <= 1'b0;
        end
      end else if (r_cnt != w_lim) begin
        r_cnt <= r_cnt + 32'd1;
      end else begin
        r_cnt  <= '0;
        r_nbit <= r_nbit + 4'd1;
        if (r_nbit == 4'd0) begin
          if (r_s2) r_act <= 1'b0;
        end else if (r_nbit == 4'd9) begin
          r_act <= 1'b0; r_data <= r_sh; r_ferr <= ~r_s2; r_ready <= 1'b1;
        end else begin
          r_sh <= {r_s2, r_sh[7:1]};
        end
      end
    end
  end

  assign o_data  = r_data;
  assign o_ready = r_ready;
  assign o_ferr  = r_ferr;
endmodule

module uart_loader_host #(
  parameter int CLK_PER_HALF_BIT = 217,
  parameter int IDLE_TIMEOUT     = 1000000
) (
  input  wire logic         clk,
  input  wire logic         rst_uart,
  input  wire logic         rxd,
  output logic              txd,
  uart_loader_host_if.slave bus
);
`ifdef UART_HOST_FERR_EN
  localparam logic c_FERR_EN = 1'b1;
`else
  localparam logic c_FERR_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_SYNC, S_SEND_SIZE, S_FETCH, S_SEND_WORD, S_WAIT_ACK, S_STREAM, S_DONE
  } state_t;

  state_t      r_state;
  logic [31:0] r_wcnt, r_idx, r_shift, r_idle, r_rom_addr;
  logic [1:0]  r_bcnt;
  logic [7:0]  r_sdata, r_out_data;
  logic        r_tx_start, r_tx_wait, r_fwait, r_rx_seen;
  logic        r_out_valid, r_busy, r_done, r_err;
  logic        w_tx_busy, w_rx_ready, w_rx_ferr;
  logic [7:0]  w_rx_data;
  logic        w_take, w_drop, w_good, w_byte_done, w_sending;

  uart_tx #(.CLK_PER_HALF_BIT(CLK_PER_HALF_BIT)) u_tx (
    .clk(clk), .rst(rst_uart), .i_start(r_tx_start), .i_data(r_sdata),
    .o_txd(txd), .o_busy(w_tx_busy)
  );

  uart_rx #(.CLK_PER_HALF_BIT(CLK_PER_HALF_BIT)) u_rx (
    .clk(clk), .rst(rst_uart), .i_rxd(rxd),
    .o_data(w_rx_data), .o_ready(w_rx_ready), .o_ferr(w_rx_ferr)
  );

  // A level-high ready is consumed only on its first cycle.
  assign w_take      = w_rx_ready & ~r_rx_seen;
  assign w_drop      = w_take & w_rx_ferr & c_FERR_EN;
  assign w_good      = w_take & ~w_drop;
  assign w_byte_done = r_tx_wait & ~w_tx_busy;
  assign w_sending   = (r_state == S_SEND_SIZE) || (r_state == S_SEND_WORD);

  always_ff @(posedge clk or posedge rst_uart) begin
    if (rst_uart) begin
      r_state <= S_IDLE; r_wcnt <= '0; r_idx <= '0; r_shift <= '0; r_idle <= '0;
      r_rom_addr <= '0; r_bcnt <= '0; r_sdata <= '0; r_out_data <= '0;
      r_tx_start <= 1'b0; r_tx_wait <= 1'b0; r_fwait <= 1'b0; r_rx_seen <= 1'b0;
      r_out_valid <= 1'b0; r_busy <= 1'b0; r_done <= 1'b0; r_err <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      r_rx_seen   <= w_rx_ready;
      if ((w_sending || r_state == S_FETCH) && w_take) r_err <= 1'b1;
      if (w_sending) begin
        if (!r_tx_start && !r_tx_wait) begin
          r_sdata <= r_shift[7:0]; r_tx_start <= 1'b1;
        end else if (r_tx_start && w_tx_busy) begin
          r_tx_start <= 1'b0; r_tx_wait <= 1'b1;
        end else if (w_byte_done) begin
          r_tx_wait <= 1'b0; r_shift <= {8'h00, r_shift[31:8]}; r_bcnt <= r_bcnt + 2'd1;
        end
      end
      case (r_state)
        S_IDLE, S_DONE: if (bus.start) begin
          r_wcnt <= bus.prog_words; r_idx <= '0; r_rom_addr <= '0;
          r_done <= 1'b0; r_err <= 1'b0; r_busy <= 1'b1; r_state <= S_WAIT_SYNC;
        end
        S_WAIT_SYNC: if (w_drop) r_err <= 1'b1;
          else if (w_good) begin
            if (w_rx_data == 8'h99) begin
              r_shift <= {r_wcnt[29:0], 2'b00}; r_bcnt <= '0; r_state <= S_SEND_SIZE;
            end else r_err <= 1'b1;
          end
        S_SEND_SIZE: if (w_byte_done && r_bcnt == 2'd3) begin
          if (r_wcnt == 32'd0) r_state <= S_WAIT_ACK;
          else begin
            r_rom_addr <= '0; r_fwait <= 1'b0; r_state <= S_FETCH;
          end
        end
        S_FETCH: if (!r_fwait) r_fwait <= 1'b1;
          else begin
            r_shift <= bus.rom_data; r_bcnt <= '0; r_fwait <= 1'b0; r_state <= S_SEND_WORD;
          end
        S_SEND_WORD: if (w_byte_done && r_bcnt == 2'd3) begin
          if (r_idx == r_wcnt - 32'd1) r_state <= S_WAIT_ACK;
          else begin
            r_idx <= r_idx + 32'd1; r_rom_addr <= r_rom_addr + 32'd1;
            r_fwait <= 1'b0; r_state <= S_FETCH;
          end
        end
        S_WAIT_ACK: if (w_drop) r_err <= 1'b1;
          else if (w_good) begin
            if (w_rx_data == 8'haa) begin
              r_idle <= '0; r_state <= S_STREAM;
            end else r_err <= 1'b1;
          end
        S_STREAM: if (w_take) begin
            r_idle <= '0;
            if (w_drop) r_err <= 1'b1;
            else begin
              r_out_data <= w_rx_data; r_out_valid <= 1'b1;
            end
          end else if (r_idle == 32'(IDLE_TIMEOUT - 1)) begin
            r_busy <= 1'b0; r_done <= 1'b1; r_state <= S_DONE;
          end else r_idle <= r_idle + 32'd1;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.rom_addr  = r_rom_addr;
  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_out_valid;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.err       = r_err;
endmodule

`default_nettype wire

// File: tb/tb_uart_loader_host.sv
// +----------------------------------------------------------------------+
// | tb_uart_loader_host : directed bench with a byte-level loader model  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_uart_loader_host;
  localparam int H   = 4;
  localparam int BIT = 2 * H;
  localparam int TO  = 300;

  logic clk = 1'b0;
  logic rst_uart;
  logic rxd;
  logic txd;
  uart_loader_host_if bus();

  uart_loader_host #(.CLK_PER_HALF_BIT(H), .IDLE_TIMEOUT(TO)) dut (
    .clk(clk), .rst_uart(rst_uart), .rxd(rxd), .txd(txd), .bus(bus)
  );

  always #5 clk = ~clk;

  logic [31:0] rom [0:3];
  always @(posedge clk) bus.rom_data <= rom[bus.rom_addr[1:0]];

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_tx[$];
  logic [7:0] exp_out[$];
  logic [7:0] tx_log[$];
  int out_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Loader-protocol model: size = 4*words (mod 2^32), then each ROM word, LSB first.
  task automatic model_tx(input logic [31:0] pw);
    logic [31:0] sz;
    logic [31:0] w;
    sz = pw * 32'd4;
    for (int k = 0; k < 4; k++) exp_tx.push_back(8'((sz >> (8 * k)) & 32'hff));
    for (int i = 0; i < int'(pw); i++) begin
      w = rom[i];
      for (int k = 0; k < 4; k++) exp_tx.push_back(8'((w >> (8 * k)) & 32'hff));
    end
  endtask

  // Line decoder for txd plus the out_valid scoreboard, sampled on the falling edge.
  int tx_ph = 0, tx_cnt = 0, tx_bit = 0;
  logic [7:0] tx_sh;
  always @(negedge clk) begin
    if (rst_uart) tx_ph = 0;
    else begin
      case (tx_ph)
        0: if (txd === 1'b0) begin tx_ph = 1; tx_cnt = H; end
        1: begin
          tx_cnt = tx_cnt - 1;
          if (tx_cnt == 0) begin
            if (txd === 1'b0) begin tx_ph = 2; tx_cnt = BIT; tx_bit = 0; end
            else tx_ph = 0;
          end
        end
        2: begin
          tx_cnt = tx_cnt - 1;
          if (tx_cnt == 0) begin
            tx_sh[tx_bit] = txd;
            tx_bit++;
            tx_cnt = BIT;
            if (tx_bit == 8) tx_ph = 3;
          end
        end
        default: begin
          tx_cnt = tx_cnt - 1;
          if (tx_cnt == 0) begin
            tx_ph = 0;
            check("tx_stop_bit", 32'(txd), 32'd1);
            tx_log.push_back(tx_sh);
            if (exp_tx.size() == 0) check("tx_unexpected_byte", 32'(tx_sh), 32'h100);
            else check("tx_byte", 32'(tx_sh), 32'(exp_tx.pop_front()));
          end
        end
      endcase
      if (bus.out_valid === 1'b1) begin
        out_cnt++;
        if (exp_out.size() == 0) check("out_unexpected", 32'(bus.out_data), 32'h100);
        else check("out_data", 32'(bus.out_data), 32'(exp_out.pop_front()));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rxd = 1'b0; repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin rxd = b[i]; repeat (BIT) @(negedge clk); end
    rxd = stop_bit; repeat (BIT) @(negedge clk);
    rxd = 1'b1; repeat (BIT) @(negedge clk);
  endtask

  task automatic do_start(input logic [31:0] pw);
    @(negedge clk); bus.start = 1'b1; bus.prog_words = pw;
    @(negedge clk); bus.start = 1'b0;
  endtask

  task automatic wait_tx(input int n, input int budget);
    int k = 0;
    while (tx_log.size() < n && k < budget) begin @(negedge clk); k++; end
    check("tx_count_reached", 32'(tx_log.size()), 32'(n));
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (bus.done !== 1'b1 && k < budget) begin @(negedge clk); k++; end
    check("done_reached", 32'(bus.done), 32'd1);
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] lit [12];
    int base, ocnt;
    lit = '{8'h08, 8'h00, 8'h00, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'h0F, 8'h0F, 8'hA5, 8'hA5};
    rxd = 1'b1; bus.start = 1'b0; bus.prog_words = '0; rst_uart = 1'b1;
    for (int i = 0; i < 4; i++) rom[i] = '0;
    repeat (3) @(negedge clk);
    check("rst_txd", 32'(txd), 32'd1);
    check("rst_rom_addr", bus.rom_addr, 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    rst_uart = 1'b0;
    repeat (2) @(negedge clk);

    // Two-word program, then a three-byte result stream.
    rom[0] = 32'h11223344; rom[1] = 32'hA5A50F0F;
    model_tx(32'd2);
    base = tx_log.size();
    do_start(32'd2);
    check("run1_busy_after_start", 32'(bus.busy), 32'd1);
    send_byte(8'h99, 1'b1);
    wait_tx(base + 12, 3000);
    repeat (10) @(negedge clk);
    for (int i = 0; i < 12; i++) check("run1_txd_literal", 32'(tx_log[base + i]), 32'(lit[i]));
    check("run1_wait_ack_busy", 32'(bus.busy), 32'd1);
    check("run1_wait_ack_done", 32'(bus.done), 32'd0);
    check("run1_rom_addr_last", bus.rom_addr, 32'd1);
    exp_out.push_back(8'h50); exp_out.push_back(8'h33); exp_out.push_back(8'h0A);
    ocnt = out_cnt;
    send_byte(8'hAA, 1'b1); send_byte(8'h50, 1'b1); send_byte(8'h33, 1'b1); send_byte(8'h0A, 1'b1);
    wait_done(2000);
    check("run1_out_pulses", 32'(out_cnt - ocnt), 32'd3);
    check("run1_err", 32'(bus.err), 32'd0);
    check("run1_busy_done", 32'(bus.busy), 32'd0);
    check("run1_out_left", 32'(exp_out.size()), 32'd0);

    // Garbage before sync sets err, transfer still completes.
    rom[0] = 32'hDEADBEEF;
    model_tx(32'd1);
    base = tx_log.size();
    do_start(32'd1);
    check("run2_done_cleared", 32'(bus.done), 32'd0);
    send_byte(8'h12, 1'b1);
    check("run2_err_set", 32'(bus.err), 32'd1);
    send_byte(8'h99, 1'b1);
    wait_tx(base + 8, 2000);
    repeat (10) @(negedge clk);
    send_byte(8'hAA, 1'b1);
    wait_done(2000);
    check("run2_err_sticky", 32'(bus.err), 32'd1);

    // Zero-length program; new start clears err; held ready gives one pulse.
    model_tx(32'd0);
    base = tx_log.size();
    do_start(32'd0);
    check("run3_err_cleared", 32'(bus.err), 32'd0);
    send_byte(8'h99, 1'b1);
    wait_tx(base + 4, 1000);
    repeat (200) @(negedge clk);
    check("run3_only_size_bytes", 32'(tx_log.size()), 32'(base + 4));
    check("run3_no_fetch_addr", bus.rom_addr, 32'd0);
    check("run3_busy", 32'(bus.busy), 32'd1);
    send_byte(8'hAA, 1'b1);
    exp_out.push_back(8'h41);
    ocnt = out_cnt;
    send_byte(8'h41, 1'b1);
    repeat (60) @(negedge clk);
    check("run3_single_pulse", 32'(out_cnt - ocnt), 32'd1);
    check("run3_stream_busy", 32'(bus.busy), 32'd1);
    wait_done(2000);
    check("run3_out_data_held", 32'(bus.out_data), 32'h41);

    // Asynchronous reset in the middle of a word, then a full rerun.
    rom[0] = 32'h11223344; rom[1] = 32'hA5A50F0F;
    model_tx(32'd2);
    base = tx_log.size();
    do_start(32'd2);
    send_byte(8'h99, 1'b1);
    wait_tx(base + 5, 2000);
    rst_uart = 1'b1;
    #1;
    check("arst_busy", 32'(bus.busy), 32'd0);
    check("arst_done", 32'(bus.done), 32'd0);
    check("arst_err", 32'(bus.err), 32'd0);
    check("arst_rom_addr", bus.rom_addr, 32'd0);
    check("arst_out_data", 32'(bus.out_data), 32'd0);
    check("arst_out_valid", 32'(bus.out_valid), 32'd0);
    check("arst_txd", 32'(txd), 32'd1);
    repeat (3) @(negedge clk);
    rst_uart = 1'b0;
    exp_tx.delete();
    repeat (20) @(negedge clk);
    model_tx(32'd2);
    base = tx_log.size();
    do_start(32'd2);
    send_byte(8'h99, 1'b1);
    wait_tx(base + 12, 3000);
    repeat (10) @(negedge clk);
    send_byte(8'hAA, 1'b1);
    exp_out.push_back(8'h7E);
    send_byte(8'h7E, 1'b1);
`ifdef UART_HOST_FERR_EN
    ocnt = out_cnt;
    send_byte(8'h5A, 1'b0);
    repeat (4) @(negedge clk);
    check("ferr_err_set", 32'(bus.err), 32'd1);
    check("ferr_no_pulse", 32'(out_cnt - ocnt), 32'd0);
`endif
    wait_done(2000);
    check("run4_tx_left", 32'(exp_tx.size()), 32'd0);
    check("run4_out_left", 32'(exp_out.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

`default_nettype wire
